// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : mips_pkg
//  Purpose : Shared register-file constants for the MIPS datapath blocks.
//  Ports   : none (package)
//  Revision: 1.0 - initial release
// ============================================================================
package mips_pkg;

  localparam int                REG_AW   = 5;
  localparam int                DATA_W   = 32;
  localparam int                NUM_REGS = 32;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
//  Module  : wb_fifo
//  Purpose : Write-back queue with two push ports and one pop port.
//            Push port 0 is the older entry when both push together.
//            Exposes per-entry valid/address for pending-write tracking.
//  Ports   : clk, reset          - clock, synchronous active-high reset
//            push0_*/push1_*     - enqueue requests (caller guarantees space)
//            pop_i               - dequeue head (caller guarantees non-empty)
//            count_o             - occupied entries
//            head_addr_o/_data_o - head entry, zero when empty
//            ent_valid_o/ent_addr_o - per-slot occupancy and destination
//  Revision: 1.0 - initial release
// ============================================================================
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push0_i,
  input  logic [AW-1:0]               push0_addr_i,
  input  logic [DW-1:0]               push0_data_i,
  input  logic                        push1_i,
  input  logic [AW-1:0]               push1_addr_i,
  input  logic [DW-1:0]               push1_data_i,
  input  logic                        pop_i,
  output logic [$clog2(DEPTH):0]      count_o,
  output logic [AW-1:0]               head_addr_o,
  output logic [DW-1:0]               head_data_o,
  output logic [DEPTH-1:0]            ent_valid_o,
  output logic [DEPTH-1:0][AW-1:0]    ent_addr_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic [PW-1:0] idx1;

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];

  // Pointers are exactly PW bits wide, so the additions wrap modulo DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push0_i) + PW'(push1_i);
    rd_ptr_d = rd_ptr_q + PW'(pop_i);
    count_d  = count_q + CW'(push0_i) + CW'(push1_i) - CW'(pop_i);
  end

  // A lone push1 lands in the current tail slot; after push0 it takes the next.
  assign idx1 = wr_ptr_q + PW'(push0_i);

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: occupancy is tracked by pointers/count.
  always_ff @(posedge clk) begin
    if (push0_i) begin
      addr_q[wr_ptr_q] <= push0_addr_i;
      data_q[wr_ptr_q] <= push0_data_i;
    end
    if (push1_i) begin
      addr_q[idx1] <= push1_addr_i;
      data_q[idx1] <= push1_data_i;
    end
  end

  assign count_o     = count_q;
  assign head_addr_o = (count_q != '0) ? addr_q[rd_ptr_q] : '0;
  assign head_data_o = (count_q != '0) ? data_q[rd_ptr_q] : '0;

  // A slot is live when its distance from the read pointer is below count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [PW-1:0] offset;
    assign offset         = PW'(i) - rd_ptr_q;
    assign ent_valid_o[i] = CW'(offset) < count_q;
    assign ent_addr_o[i]  = addr_q[i];
  end

endmodule : wb_fifo
`default_nettype wire

// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : rf_write_arbiter
//  Purpose : Drives the register file's single write port from two producers
//            (load/mult-div "mem" and ALU) through a small queue. Writes are
//            held off while the register file is reading. Also exports a
//            pending-write mask for hazard detection.
//  Ports   : clk, reset                     - clock, sync active-high reset
//            mem_valid/ready/waddr/wdata    - load/mult-div result handshake
//            alu_valid/ready/waddr/wdata    - ALU result handshake
//            rf_re                          - register file read this cycle
//            rf_we/rf_waddr/rf_wdata        - register file write port
//            busy_mask                      - queued write pending per register
//            count                          - occupied queue entries
//  Revision: 1.0 - initial release
// ============================================================================
module rf_write_arbiter
  import mips_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = REG_AW,
  parameter int DW    = DATA_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mem_valid,
  output logic                   mem_ready,
  input  logic [AW-1:0]          mem_waddr,
  input  logic [DW-1:0]          mem_wdata,
  input  logic                   alu_valid,
  output logic                   alu_ready,
  input  logic [AW-1:0]          alu_waddr,
  input  logic [DW-1:0]          alu_wdata,
  input  logic                   rf_re,
  output logic                   rf_we,
  output logic [AW-1:0]          rf_waddr,
  output logic [DW-1:0]          rf_wdata,
  output logic [NUM_REGS-1:0]    busy_mask,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]           free;
  logic                    mem_push;
  logic                    alu_push;
  logic [DEPTH-1:0]        ent_valid;
  logic [DEPTH-1:0][AW-1:0] ent_addr;

  // Space is judged on registered occupancy only; a pop in this cycle does
  // not free a slot for this cycle's producers.
  assign free      = CW'(DEPTH) - count;
  assign mem_ready = (free >= CW'(1));
  // The ALU may take the last slot only when mem is not competing for it.
  assign alu_ready = (free >= CW'(2)) | (!mem_valid & (free >= CW'(1)));

  // Writes to register zero complete the handshake but are dropped here.
  assign mem_push = mem_valid & mem_ready & (mem_waddr != AW'(REG_ZERO));
  assign alu_push = alu_valid & alu_ready & (alu_waddr != AW'(REG_ZERO));

  assign rf_we = (count != '0) & !rf_re;

  wb_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push0_i      (mem_push),
    .push0_addr_i (mem_waddr),
    .push0_data_i (mem_wdata),
    .push1_i      (alu_push),
    .push1_addr_i (alu_waddr),
    .push1_data_i (alu_wdata),
    .pop_i        (rf_we),
    .count_o      (count),
    .head_addr_o  (rf_waddr),
    .head_data_o  (rf_wdata),
    .ent_valid_o  (ent_valid),
    .ent_addr_o   (ent_addr)
  );

  // Bit 0 is never set since register-zero writes are never queued.
  always_comb begin
    busy_mask = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      for (int e = 0; e < DEPTH; e++) begin
        if (ent_valid[e] && (ent_addr[e] == AW'(r))) begin
          busy_mask[r] = 1'b1;
        end
      end
    end
  end

endmodule : rf_write_arbiter
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : tb_rf_write_arbiter
//  Purpose : Directed self-checking bench for rf_write_arbiter.
//  Ports   : none
//  Revision: 1.0 - initial release
// ============================================================================
module tb_rf_write_arbiter;

  logic        clk;
  logic        reset;
  logic        mem_valid, alu_valid, rf_re;
  logic        mem_ready, alu_ready, rf_we;
  logic [4:0]  mem_waddr, alu_waddr, rf_waddr;
  logic [31:0] mem_wdata, alu_wdata, rf_wdata, busy_mask;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  rf_write_arbiter #(.DEPTH(4), .AW(5), .DW(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_waddr (alu_waddr),
    .alu_wdata (alu_wdata),
    .rf_re     (rf_re),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .busy_mask (busy_mask),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_mem(input logic v, input logic [4:0] a, input logic [31:0] d);
    mem_valid = v; mem_waddr = a; mem_wdata = d;
  endtask

  task automatic drive_alu(input logic v, input logic [4:0] a, input logic [31:0] d);
    alu_valid = v; alu_waddr = a; alu_wdata = d;
  endtask

  logic [4:0]  exp_a [4];
  logic [31:0] exp_d [4];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; rf_re = 1'b0;
    drive_mem(1'b0, 5'd0, 32'h0);
    drive_alu(1'b0, 5'd0, 32'h0);
    tick(); tick();
    reset = 1'b0;
    check("rst_count", 32'(count), 32'd0);
    check("rst_we", 32'(rf_we), 32'd0);
    check("rst_busy", busy_mask, 32'h0);
    check("rst_mem_ready", 32'(mem_ready), 32'd1);
    check("rst_alu_ready", 32'(alu_ready), 32'd1);

    // 1. reset with three entries queued
    rf_re = 1'b1;
    drive_mem(1'b1, 5'd1, 32'hA1);
    drive_alu(1'b1, 5'd2, 32'hA2);
    tick();
    drive_mem(1'b1, 5'd4, 32'hA4);
    drive_alu(1'b0, 5'd0, 32'h0);
    tick();
    drive_mem(1'b0, 5'd0, 32'h0);
    check("q3_count", 32'(count), 32'd3);
    check("q3_busy", busy_mask, 32'h16);
    reset = 1'b1;
    tick();
    reset = 1'b0; rf_re = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("midrst_count", 32'(count), 32'd0);
      check("midrst_we", 32'(rf_we), 32'd0);
      check("midrst_busy", busy_mask, 32'h0);
      tick();
    end

    // 2. single ALU write
    drive_alu(1'b1, 5'd5, 32'hDEADBEEF);
    check("alu1_ready", 32'(alu_ready), 32'd1);
    tick();
    drive_alu(1'b0, 5'd0, 32'h0);
    check("alu1_we", 32'(rf_we), 32'd1);
    check("alu1_addr", 32'(rf_waddr), 32'd5);
    check("alu1_data", rf_wdata, 32'hDEADBEEF);
    check("alu1_busy", busy_mask, 32'h20);
    tick();
    check("alu1_count", 32'(count), 32'd0);
    check("alu1_we_off", 32'(rf_we), 32'd0);
    check("empty_addr", 32'(rf_waddr), 32'd0);

    // 3. dual push, mem older
    drive_mem(1'b1, 5'd3, 32'h11);
    drive_alu(1'b1, 5'd3, 32'h22);
    check("dual_mem_ready", 32'(mem_ready), 32'd1);
    check("dual_alu_ready", 32'(alu_ready), 32'd1);
    tick();
    drive_mem(1'b0, 5'd0, 32'h0);
    drive_alu(1'b0, 5'd0, 32'h0);
    check("dual_count", 32'(count), 32'd2);
    check("dual_busy", busy_mask, 32'h8);
    check("dual_w0_we", 32'(rf_we), 32'd1);
    check("dual_w0_addr", 32'(rf_waddr), 32'd3);
    check("dual_w0_data", rf_wdata, 32'h11);
    tick();
    check("dual_w1_we", 32'(rf_we), 32'd1);
    check("dual_w1_addr", 32'(rf_waddr), 32'd3);
    check("dual_w1_data", rf_wdata, 32'h22);
    tick();
    check("dual_done", 32'(count), 32'd0);

    // 4. register-zero filter
    drive_alu(1'b1, 5'd0, 32'hFFFFFFFF);
    check("zero_ready", 32'(alu_ready), 32'd1);
    tick();
    drive_alu(1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      check("zero_count", 32'(count), 32'd0);
      check("zero_we", 32'(rf_we), 32'd0);
      check("zero_busy", busy_mask, 32'h0);
      tick();
    end

    // 5. read blocking
    rf_re = 1'b1;
    drive_alu(1'b1, 5'd7, 32'h7);
    tick();
    drive_alu(1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      check("rdblk_we", 32'(rf_we), 32'd0);
      check("rdblk_count", 32'(count), 32'd1);
      if (i < 2) tick();
    end
    rf_re = 1'b0;
    #1;
    check("rdrel_we", 32'(rf_we), 32'd1);
    check("rdrel_addr", 32'(rf_waddr), 32'd7);
    check("rdrel_data", rf_wdata, 32'h7);
    tick();
    check("rdrel_count", 32'(count), 32'd0);

    // 6. backpressure and drain order
    rf_re = 1'b1;
    drive_mem(1'b1, 5'd8, 32'h80);
    drive_alu(1'b1, 5'd9, 32'h90);
    tick();
    drive_alu(1'b0, 5'd0, 32'h0);
    drive_mem(1'b1, 5'd10, 32'hA0);
    check("bp2_alu_ready", 32'(alu_ready), 32'd1);
    tick();
    drive_mem(1'b0, 5'd0, 32'h0);
    #1;
    check("bp3_count", 32'(count), 32'd3);
    check("bp3_alu_alone", 32'(alu_ready), 32'd1);
    drive_mem(1'b1, 5'd11, 32'hB0);
    drive_alu(1'b1, 5'd12, 32'hC0);
    #1;
    check("bp3_mem_ready", 32'(mem_ready), 32'd1);
    check("bp3_alu_ready", 32'(alu_ready), 32'd0);
    tick();
    check("bp4_count", 32'(count), 32'd4);
    check("bp4_mem_ready", 32'(mem_ready), 32'd0);
    check("bp4_alu_ready", 32'(alu_ready), 32'd0);
    check("bp4_busy", busy_mask, 32'h00000F00);
    drive_mem(1'b0, 5'd0, 32'h0);
    drive_alu(1'b0, 5'd0, 32'h0);
    rf_re = 1'b0;
    #1;
    check("full_pop_mem_ready", 32'(mem_ready), 32'd0);
    check("full_pop_alu_ready", 32'(alu_ready), 32'd0);
    exp_a[0] = 5'd8;  exp_d[0] = 32'h80;
    exp_a[1] = 5'd9;  exp_d[1] = 32'h90;
    exp_a[2] = 5'd10; exp_d[2] = 32'hA0;
    exp_a[3] = 5'd11; exp_d[3] = 32'hB0;
    for (int i = 0; i < 4; i++) begin
      check("drain_we", 32'(rf_we), 32'd1);
      check("drain_addr", 32'(rf_waddr), 32'(exp_a[i]));
      check("drain_data", rf_wdata, exp_d[i]);
      tick();
    end
    check("drain_count", 32'(count), 32'd0);
    check("drain_we_off", 32'(rf_we), 32'd0);
    check("drain_busy", busy_mask, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_rf_write_arbiter
`default_nettype wire
